// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes RX frames into register-file and ALU
// operations and returns read/ALU results through the TX FIFO.
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]   RF_ADDRESS,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic [3:0]              ALU_FUN,
    output logic                    ALU_EN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_FUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    single;
    logic [CW-1:0]           tmo_cnt;
    logic                    timed_out;

    assign timed_out = (tmo_cnt == CW'(TIMEOUT));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            addr_q      <= '0;
            result      <= '0;
            single      <= 1'b0;
            tmo_cnt     <= '0;
            RF_ADDRESS  <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_WR_DATA  <= '0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;
            case (state)
                IDLE: if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        OP_WR: state <= WR_ADDR;
                        OP_RD: state <= RD_ADDR;
                        OP_ALU: begin
                            state       <= ALU_A;
                            CLK_GATE_EN <= 1'b1;
                        end
                        OP_FUN: begin
                            state       <= ALU_FUNC;
                            CLK_GATE_EN <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
                WR_ADDR: if (RX_D_VLD) begin
                    addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
                    state  <= WR_DATA;
                end
                WR_DATA: if (RX_D_VLD) begin
                    RF_WR_EN   <= 1'b1;
                    RF_ADDRESS <= addr_q;
                    RF_WR_DATA <= RX_P_DATA;
                    state      <= IDLE;
                end
                RD_ADDR: if (RX_D_VLD) begin
                    RF_RD_EN   <= 1'b1;
                    RF_ADDRESS <= RX_P_DATA[ADDR_WIDTH-1:0];
                    tmo_cnt    <= '0;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    // a valid pulse on the last allowed cycle still wins
                    if (RF_RD_DATA_VLD) begin
                        result <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                        single <= 1'b1;
                        state  <= TX_LO;
                    end else if (timed_out) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                ALU_A: if (RX_D_VLD) begin
                    RF_WR_EN   <= 1'b1;
                    RF_ADDRESS <= '0;
                    RF_WR_DATA <= RX_P_DATA;
                    state      <= ALU_B;
                end
                ALU_B: if (RX_D_VLD) begin
                    RF_WR_EN   <= 1'b1;
                    RF_ADDRESS <= ADDR_WIDTH'(1);
                    RF_WR_DATA <= RX_P_DATA;
                    state      <= ALU_FUNC;
                end
                ALU_FUNC: if (RX_D_VLD) begin
                    ALU_FUN <= RX_P_DATA[3:0];
                    ALU_EN  <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= ALU_WAIT;
                end
                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        result      <= ALU_OUT;
                        single      <= 1'b0;
                        CLK_GATE_EN <= 1'b0;
                        state       <= TX_LO;
                    end else if (timed_out) begin
                        CLK_GATE_EN <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                TX_LO: if (!FIFO_FULL) begin
                    TX_D_VLD  <= 1'b1;
                    TX_P_DATA <= result[DATA_WIDTH-1:0];
                    state     <= single ? IDLE : TX_HI;
                end
                TX_HI: if (!FIFO_FULL) begin
                    TX_D_VLD  <= 1'b1;
                    TX_P_DATA <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: write, read, ALU, drop, timeout
// and reset sequences with hand-computed expectations.
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_DATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [3:0]  RF_ADDRESS;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [7:0]  RF_WR_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  int n_assert = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;
  int wr_cnt   = 0;
  int snap_tx;
  int snap_wr;
  logic [28:0] outs;

  uart_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA),
    .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA),
    .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .RF_ADDRESS(RF_ADDRESS),
    .RF_WR_EN(RF_WR_EN),
    .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA),
    .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN),
    .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  assign outs = {RF_ADDRESS, RF_WR_EN,
                 RF_RD_EN, RF_WR_DATA,
                 ALU_FUN, ALU_EN,
                 CLK_GATE_EN, TX_P_DATA,
                 TX_D_VLD};

  always @(negedge CLK) begin
    if (TX_D_VLD) tx_cnt++;
    if (RF_WR_EN) wr_cnt++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("reset_outs", outs, 0);
    RST = 1'b1;
    step();

    snap_tx = tx_cnt;
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    chk("wr_en", RF_WR_EN, 1);
    chk("wr_addr", RF_ADDRESS, 4'h5);
    chk("wr_data", RF_WR_DATA, 8'h3C);
    step();
    chk("wr_en_pulse", RF_WR_EN, 0);
    chk("wr_no_tx", tx_cnt - snap_tx, 0);

    FIFO_FULL = 1'b1;
    snap_tx = tx_cnt;
    send(8'hBB);
    send(8'h07);
    chk("rd_en", RF_RD_EN, 1);
    chk("rd_addr", RF_ADDRESS, 4'h7);
    send(8'hAA);
    chk("rd_en_pulse", RF_RD_EN, 0);
    step();
    RF_RD_DATA = 8'h5A;
    RF_RD_DATA_VLD = 1'b1;
    step();
    RF_RD_DATA_VLD = 1'b0;
    repeat (4) step();
    chk("rd_hold_full", tx_cnt - snap_tx, 0);
    FIFO_FULL = 1'b0;
    step();
    chk("rd_tx_vld", TX_D_VLD, 1);
    chk("rd_tx_data", TX_P_DATA, 8'h5A);
    repeat (3) step();
    chk("rd_one_push", tx_cnt - snap_tx, 1);

    send(8'hCC);
    chk("cc_gate", CLK_GATE_EN, 1);
    send(8'h12);
    chk("opa_wr",
        {RF_WR_EN, RF_ADDRESS, RF_WR_DATA},
        {1'b1, 4'h0, 8'h12});
    send(8'h34);
    chk("opb_wr",
        {RF_WR_EN, RF_ADDRESS, RF_WR_DATA},
        {1'b1, 4'h1, 8'h34});
    send(8'h02);
    chk("alu_en",
        {ALU_EN, ALU_FUN, CLK_GATE_EN},
        {1'b1, 4'h2, 1'b1});
    step();
    chk("alu_en_pulse",
        {ALU_EN, CLK_GATE_EN}, 2'b01);
    ALU_OUT = 16'h0246;
    ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    chk("alu_gate_off", CLK_GATE_EN, 0);
    step();
    chk("alu_tx_lo",
        {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h46});
    step();
    chk("alu_tx_hi",
        {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h02});
    step();
    chk("alu_tx_end", TX_D_VLD, 0);

    snap_wr = wr_cnt;
    snap_tx = tx_cnt;
    send(8'hDD);
    chk("dd_gate", CLK_GATE_EN, 1);
    send(8'h01);
    chk("dd_alu_en",
        {ALU_EN, ALU_FUN}, {1'b1, 4'h1});
    step();
    ALU_OUT = 16'h8899;
    ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    step();
    chk("dd_tx_lo",
        {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h99});
    step();
    chk("dd_tx_hi",
        {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h88});
    step();
    ALU_OUT_VLD = 1'b1;
    RF_RD_DATA_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    RF_RD_DATA_VLD = 1'b0;
    repeat (3) step();
    chk("dd_pushes", tx_cnt - snap_tx, 2);
    chk("dd_no_wr", wr_cnt - snap_wr, 0);

    send(8'h55);
    chk("ill_outs",
        {RF_WR_EN, RF_RD_EN, ALU_EN,
         TX_D_VLD, CLK_GATE_EN}, 0);
    send(8'hAA);
    send(8'h02);
    send(8'h77);
    chk("ill_then_wr",
        {RF_WR_EN, RF_ADDRESS, RF_WR_DATA},
        {1'b1, 4'h2, 8'h77});

    snap_tx = tx_cnt;
    send(8'hBB);
    send(8'h03);
    chk("to_rd_en",
        {RF_RD_EN, RF_ADDRESS}, {1'b1, 4'h3});
    repeat (256) step();
    chk("to_no_push", tx_cnt - snap_tx, 0);
    send(8'hAA);
    send(8'h09);
    send(8'h66);
    chk("to_then_wr",
        {RF_WR_EN, RF_ADDRESS, RF_WR_DATA},
        {1'b1, 4'h9, 8'h66});

    snap_tx = tx_cnt;
    send(8'hBB);
    send(8'h04);
    repeat (255) step();
    RF_RD_DATA = 8'hC3;
    RF_RD_DATA_VLD = 1'b1;
    step();
    RF_RD_DATA_VLD = 1'b0;
    step();
    chk("to_edge_tx",
        {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hC3});
    chk("to_edge_cnt", tx_cnt - snap_tx, 0);

    step();
    send(8'hDD);
    send(8'h03);
    chk("rst_pre_gate", CLK_GATE_EN, 1);
    step();
    snap_tx = tx_cnt;
    RST = 1'b0;
    #1;
    chk("rst_outs", outs, 0);
    chk("rst_gate", CLK_GATE_EN, 0);
    step();
    RST = 1'b1;
    ALU_OUT = 16'hBEEF;
    ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    repeat (3) step();
    chk("rst_no_push", tx_cnt - snap_tx, 0);
    chk("rst_idle_outs",
        {RF_WR_EN, RF_RD_EN, ALU_EN,
         CLK_GATE_EN}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
